// File: rtl/rsa_rng_pkg.sv
// rsa_rng_pkg: constants and types shared by the RSA random-candidate path.
// Holds the LFSR word width, the candidate generator state encoding and a
// helper that sizes the word counters so they can hold the terminal count.
package rsa_rng_pkg;

    // Width of one word delivered by the upstream 32-bit LFSR.
    localparam int RNG_WORD_W = 32;

    // Candidate generator control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        VALID = 2'd2
    } state_t;

    // Counter width able to represent 0..words inclusive without wrapping.
    function automatic int count_width(input int words);
        return $clog2(words) + 1;
    endfunction

endpackage

// File: rtl/rng_candidate_gen_if.sv
// rng_candidate_gen_if: request, LFSR and candidate handshake signals of the
// candidate generator. The master side is the generator itself, the slave
// side is whatever drives the requests, the LFSR word and the ready.
interface rng_candidate_gen_if #(
    parameter int WIDTH = 128
);
    import rsa_rng_pkg::*;

    logic                  start;
    logic                  continuous;
    logic [RNG_WORD_W-1:0] rng_word;
    logic                  rng_en;
    logic                  cand_valid;
    logic                  cand_ready;
    logic [WIDTH-1:0]      candidate;
    logic                  busy;

    modport master (
        input  start,
        input  continuous,
        input  rng_word,
        input  cand_ready,
        output rng_en,
        output cand_valid,
        output candidate,
        output busy
    );

    modport slave (
        output start,
        output continuous,
        output rng_word,
        output cand_ready,
        input  rng_en,
        input  cand_valid,
        input  candidate,
        input  busy
    );

endinterface

// File: rtl/rng_candidate_gen.sv
// rng_candidate_gen: steps the LFSR for WORDS cycles, packs the returned words
// (first word in the MSBs) into a WIDTH-bit candidate with its top bit and
// bit 0 forced, and offers it over a valid/ready handshake.
// Build macro RNG_CAND_TOP2_EN: when defined, bit WIDTH-2 is forced as well so
// the product of two candidates is exactly 2*WIDTH bits wide.
module rng_candidate_gen
    import rsa_rng_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic                clk,
    input  logic                rst,
    rng_candidate_gen_if.master bus
);

    localparam int WORDS = WIDTH / RNG_WORD_W;
    localparam int CW    = count_width(WORDS);

    localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);
    localparam logic [CW-1:0] TERM_CNT = CW'(WORDS);

`ifdef RNG_CAND_TOP2_EN
    localparam logic [WIDTH-1:0] FORCE_MASK = {2'b11, {(WIDTH-3){1'b0}}, 1'b1};
`else
    localparam logic [WIDTH-1:0] FORCE_MASK = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
`endif

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    issue_cnt;
    logic [CW-1:0]    cap_cnt;
    logic             cap_strobe;
    logic             capture;
    logic             rng_en_int;
    logic             fill_clear;
    logic             last_cap;
    logic             handshake;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] cand_reg;

    // The LFSR is stepped only while FILL still has words left to request.
    assign rng_en_int = (state == FILL) && (issue_cnt < TERM_CNT);

    // A word is taken one cycle after its request, and only inside a fill.
    assign capture    = cap_strobe && (state == FILL);

    // New words enter at the bottom so the first one ends up in the MSBs.
    assign shreg_next = {shreg[WIDTH-RNG_WORD_W-1:0], bus.rng_word};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the one-cycle control strobes derived from it.
    always_comb begin
        state_next = state;
        fill_clear = 1'b0;
        last_cap   = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = FILL;
                    fill_clear = 1'b1;
                end
            end
            FILL: begin
                if (capture && (cap_cnt == LAST_CNT)) begin
                    state_next = VALID;
                    last_cap   = 1'b1;
                end
            end
            VALID: begin
                if (bus.cand_ready) begin
                    handshake = 1'b1;
                    if (bus.continuous) begin
                        state_next = FILL;
                        fill_clear = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Issue/capture counters and the delayed capture strobe; counters saturate at terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cnt  <= '0;
            cap_cnt    <= '0;
            cap_strobe <= 1'b0;
        end else begin
            cap_strobe <= rng_en_int;
            if (fill_clear) begin
                issue_cnt <= '0;
                cap_cnt   <= '0;
            end else begin
                if (rng_en_int) begin
                    issue_cnt <= issue_cnt + CW'(1);
                end
                if (capture && (cap_cnt != TERM_CNT)) begin
                    cap_cnt <= cap_cnt + CW'(1);
                end
            end
        end
    end

    // Word shift register and the held candidate, which reads zero outside VALID.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            cand_reg <= '0;
        end else begin
            if (capture) begin
                shreg <= shreg_next;
            end
            if (last_cap) begin
                cand_reg <= shreg_next | FORCE_MASK;
            end else if (handshake) begin
                cand_reg <= '0;
            end
        end
    end

    assign bus.rng_en     = rng_en_int;
    assign bus.cand_valid = (state == VALID);
    assign bus.candidate  = cand_reg;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_rng_candidate_gen.sv
// tb_rng_candidate_gen: scoreboard bench for rng_candidate_gen at WIDTH=64.
// A behavioural LFSR stand-in produces words; every WORDS words produced form
// one expected candidate in a queue, which a monitor pops on each handshake.
// The monitor also checks latency, rng_en usage, hold stability and IDLE outputs.
module tb_rng_candidate_gen;
    import rsa_rng_pkg::*;

    localparam int TBW   = 64;
    localparam int WORDS = TBW / RNG_WORD_W;
    localparam int BUDGET = 4 * WORDS + 8;

`ifdef RNG_CAND_TOP2_EN
    localparam logic [TBW-1:0] PACK_EXP = 64'hD23456789ABCDEF1;
    localparam logic [TBW-1:0] ZERO_EXP = 64'hC000000000000001;
    localparam logic [TBW-1:0] POST_EXP = 64'hC000BEEF1234FFFF;
`else
    localparam logic [TBW-1:0] PACK_EXP = 64'h923456789ABCDEF1;
    localparam logic [TBW-1:0] ZERO_EXP = 64'h8000000000000001;
    localparam logic [TBW-1:0] POST_EXP = 64'h8000BEEF1234FFFF;
`endif

    logic clk;
    logic rst;
    int   cycle;
    int   n_checks;
    int   n_fail;

    logic [31:0]    word_q[$];
    logic [31:0]    acc_q[$];
    logic [TBW-1:0] exp_q[$];

    rng_candidate_gen_if #(.WIDTH(TBW)) bus ();

    rng_candidate_gen #(.WIDTH(TBW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock and edge counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cycle = 0;
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    task automatic check_output(input string name, input logic [TBW-1:0] act, input logic [TBW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %h, required %h (edge %0d)", name, act, req, cycle);
        end
    endtask

    task automatic apply_stimulus(input bit s, input bit c, input bit r);
        @(posedge clk);
        #1;
        bus.start      = s;
        bus.continuous = c;
        bus.cand_ready = r;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.cand_valid && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check_output(name, TBW'(bus.cand_valid), TBW'(1));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check_output(name, TBW'(bus.busy), TBW'(0));
    endtask

    // LFSR stand-in: a step requested during a cycle yields a new word just after the next edge.
    initial begin
        bit             en_seen;
        logic [31:0]    w;
        logic [TBW-1:0] c;
        bus.rng_word = '0;
        forever begin
            @(negedge clk);
            en_seen = bus.rng_en;
            @(posedge clk);
            #1;
            if (en_seen) begin
                if (word_q.size() > 0) w = word_q.pop_front();
                else w = $urandom;
                bus.rng_word = w;
                acc_q.push_back(w);
                if (acc_q.size() == WORDS) begin
                    c = '0;
                    foreach (acc_q[k]) c = (c << RNG_WORD_W) | TBW'(acc_q[k]);
                    c[TBW-1] = 1'b1;
                    c[0]     = 1'b1;
`ifdef RNG_CAND_TOP2_EN
                    c[TBW-2] = 1'b1;
`endif
                    exp_q.push_back(c);
                    acc_q.delete();
                end
            end
        end
    end

    // Monitor: scoreboard pops on handshakes plus protocol and timing checks.
    initial begin
        bit             fill_active;
        int             fill_edge;
        int             en_cnt;
        bit             prev_valid;
        bit             prev_hs;
        bit             prev_cont;
        logic [TBW-1:0] prev_cand;
        logic [TBW-1:0] e;
        fill_active = 0;
        fill_edge   = 0;
        en_cnt      = 0;
        prev_valid  = 0;
        prev_hs     = 0;
        prev_cont   = 0;
        prev_cand   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                fill_active = 0;
                prev_valid  = 0;
                prev_hs     = 0;
                en_cnt      = 0;
            end else begin
                if (!bus.busy) begin
                    check_output("idle_outputs", TBW'({bus.cand_valid, bus.rng_en, |bus.candidate}), TBW'(0));
                end
                if (bus.rng_en) begin
                    check_output("en_only_in_fill", TBW'(bus.busy && !bus.cand_valid), TBW'(1));
                    en_cnt++;
                end
                if (prev_valid && !prev_hs) begin
                    check_output("hold_valid", TBW'(bus.cand_valid), TBW'(1));
                    check_output("hold_candidate", bus.candidate, prev_cand);
                end
                if (prev_hs) begin
                    if (prev_cont) check_output("cont_refill", TBW'({bus.busy, bus.cand_valid, bus.rng_en}), TBW'(3'b101));
                    else check_output("return_idle", TBW'({bus.busy, bus.cand_valid}), TBW'(0));
                end
                if (bus.cand_valid && !prev_valid) begin
                    check_output("valid_expected", TBW'(fill_active), TBW'(1));
                    check_output("latency", TBW'(cycle - fill_edge), TBW'(WORDS + 1));
                    check_output("en_count", TBW'(en_cnt), TBW'(WORDS));
                    fill_active = 0;
                end
                if (bus.cand_valid && bus.cand_ready) begin
                    check_output("sb_nonempty", TBW'(exp_q.size() != 0), TBW'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_output("candidate", bus.candidate, e);
                    end
                end
                if ((!bus.busy && bus.start) || (bus.cand_valid && bus.cand_ready && bus.continuous)) begin
                    fill_active = 1;
                    fill_edge   = cycle + 1;
                    en_cnt      = 0;
                end
                prev_valid = bus.cand_valid;
                prev_hs    = bus.cand_valid && bus.cand_ready;
                prev_cont  = bus.continuous;
                prev_cand  = bus.candidate;
            end
        end
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, n_fail %0d", n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized phase and a final drain.
    initial begin
        int hs;
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.continuous = 1'b0;
        bus.cand_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_output("reset_rng_en", TBW'(bus.rng_en), TBW'(0));
        check_output("reset_valid", TBW'(bus.cand_valid), TBW'(0));
        check_output("reset_busy", TBW'(bus.busy), TBW'(0));
        check_output("reset_candidate", bus.candidate, TBW'(0));
        @(posedge clk);
        #3 rst = 1'b1;

        $display("[TB] packing and backpressure");
        word_q.push_back(32'h12345678);
        word_q.push_back(32'h9ABCDEF0);
        apply_stimulus(1, 0, 0);
        apply_stimulus(0, 0, 0);
        wait_valid("pack_valid");
        check_output("pack_candidate", bus.candidate, PACK_EXP);
        repeat (10) apply_stimulus(0, 0, 0);
        @(negedge clk);
        check_output("bp_valid_held", TBW'(bus.cand_valid), TBW'(1));
        check_output("bp_candidate_held", bus.candidate, PACK_EXP);
        apply_stimulus(0, 0, 1);
        apply_stimulus(0, 0, 0);
        @(negedge clk);
        check_output("bp_idle_busy", TBW'(bus.busy), TBW'(0));

        $display("[TB] all-zero words");
        repeat (WORDS) word_q.push_back(32'h0);
        apply_stimulus(1, 0, 1);
        apply_stimulus(0, 0, 1);
        wait_valid("zero_valid");
        check_output("zero_candidate", bus.candidate, ZERO_EXP);
        apply_stimulus(0, 0, 0);
        wait_idle("zero_idle");

        $display("[TB] continuous mode with stray start");
        apply_stimulus(1, 1, 1);
        apply_stimulus(0, 1, 1);
        wait_valid("cont_first_valid");
        hs = (bus.cand_valid && bus.cand_ready) ? 1 : 0;
        for (int i = 1; i < 16; i++) begin
            apply_stimulus(i == 5, 1, 1);
            @(negedge clk);
            if (bus.cand_valid && bus.cand_ready) hs++;
        end
        check_output("cont_throughput", TBW'(hs), TBW'(16 / (WORDS + 2)));
        apply_stimulus(0, 0, 1);
        wait_idle("cont_stop_idle");
        apply_stimulus(0, 0, 0);

        $display("[TB] reset mid-fill");
        apply_stimulus(1, 0, 0);
        apply_stimulus(0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("rst_pre_busy", TBW'(bus.busy), TBW'(1));
        #2;
        rst = 1'b0;
        acc_q.delete();
        exp_q.delete();
        #1;
        check_output("rst_rng_en", TBW'(bus.rng_en), TBW'(0));
        check_output("rst_valid", TBW'(bus.cand_valid), TBW'(0));
        check_output("rst_busy", TBW'(bus.busy), TBW'(0));
        check_output("rst_candidate", bus.candidate, TBW'(0));
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        word_q.push_back(32'h0000BEEF);
        word_q.push_back(32'h1234FFFE);
        apply_stimulus(1, 0, 1);
        apply_stimulus(0, 0, 1);
        wait_valid("post_rst_valid");
        check_output("post_rst_candidate", bus.candidate, POST_EXP);
        apply_stimulus(0, 0, 0);
        wait_idle("post_rst_idle");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            apply_stimulus($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end
        apply_stimulus(0, 0, 1);
        wait_idle("drain_idle");
        apply_stimulus(0, 0, 0);
        repeat (2) @(negedge clk);
        check_output("sb_drained", TBW'(exp_q.size()), TBW'(0));
        check_output("partial_words", TBW'(acc_q.size()), TBW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
